// File: rtl/rr_arbiter.sv
// Round-robin arbiter for NUM_REQ requesters. Grants are sticky while the owner keeps
// requesting, with an optional hold limit that preempts an owner while others wait.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDX_W    = $clog2(NUM_REQ),
    localparam int HC_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [HC_W-1:0]    hold_count,
    output logic               fsm_state,
    output logic [IDX_W-1:0]   rr_ptr
);

    // Handshake: req[i] is a level request; the resource belongs to i exactly while
    // grant[i]=1, and every release is followed by one cycle with grant=0.

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [HC_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HC_W{1'b1}} : HC_W'(MAX_HOLD);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] win_onehot;
    logic               found;
    logic               owner_req;
    logic               others_req;
    logic               at_limit;
    logic               release_now;

    // Search upward from ptr, wrapping at NUM_REQ-1.
    always_comb begin
        int cand;
        cand  = 0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        win_onehot      = '0;
        win_onehot[win] = 1'b1;
    end

    assign owner_req   = |(req & grant);
    assign others_req  = |(req & ~grant);
    assign at_limit    = (MAX_HOLD != 0) && (hold_count == HOLD_SAT);
    assign release_now = !owner_req || (at_limit && others_req);
    assign next_ptr    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            hold_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state       <= GRANT;
                        grant       <= win_onehot;
                        grant_valid <= 1'b1;
                        grant_idx   <= win;
                        hold_count  <= HC_W'(1);
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state       <= IDLE;
                        ptr         <= next_ptr;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_idx   <= '0;
                        hold_count  <= '0;
                    end else if (hold_count != HOLD_SAT) begin
                        hold_count <= hold_count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fsm_state = state;
    assign rr_ptr    = ptr;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter (NUM_REQ=4, MAX_HOLD=4): directed scenarios plus random requests,
// compared cycle by cycle against an ownership-level reference model.
module tb_rr_arbiter;
    localparam int N  = 4;
    localparam int MH = 4;
    localparam int IW = 2;
    localparam int HW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic [HW-1:0] hold_count;
    logic          fsm_state;
    logic [IW-1:0] rr_ptr;

    rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clock(clock), .reset(reset), .req(req),
        .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .hold_count(hold_count), .fsm_state(fsm_state), .rr_ptr(rr_ptr)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the resource, for how long, and where the search starts.
    int m_owner;
    int m_hold;
    int m_ptr;
    logic [N-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        bit others;
        if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (m_owner < 0 && r[c]) begin
                    m_owner = c;
                    m_hold  = 1;
                end
            end
        end else begin
            others = 1'b0;
            for (int i = 0; i < N; i++)
                if (i != m_owner && r[i]) others = 1'b1;
            if (!r[m_owner] || (m_hold == MH && others)) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_hold  = 0;
            end else if (m_hold < MH) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic compare_all();
        logic [N-1:0] eg;
        eg = exp_q.pop_front();
        check("grant", 32'(grant), 32'(eg));
        check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        check("grant_idx", 32'(grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check("hold_count", 32'(hold_count), 32'(m_hold));
        check("rr_ptr", 32'(rr_ptr), 32'(m_ptr));
        check("fsm_state", 32'(fsm_state), 32'(m_owner >= 0));
    endtask

    // One clock: drive on the falling edge, update the model at the rising edge, compare 1ns later.
    task automatic cycle(input logic [N-1:0] r, input logic rst = 1'b0);
        @(negedge clock);
        req   = r;
        reset = rst;
        @(posedge clock);
        if (rst) model_reset();
        else     model_step(r);
        exp_q.push_back(model_grant());
        #1;
        compare_all();
    endtask

    task automatic repeat_cycle(input logic [N-1:0] r, input int n);
        for (int i = 0; i < n; i++) cycle(r);
    endtask

    initial begin
        logic [N-1:0] r;
        reset = 1'b1;
        req   = '0;
        model_reset();

        // Reset held two cycles, then idle.
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        repeat_cycle(4'b0000, 2);

        // Single requester 2: hold counts 1,2,3, then a dead cycle moves ptr to 3.
        repeat_cycle(4'b0100, 3);
        repeat_cycle(4'b0000, 3);

        // All requesting from ptr=0: rotation with preemption at the hold limit.
        cycle(4'b0000, 1'b1);
        repeat_cycle(4'b1111, 21);
        repeat_cycle(4'b0000, 3);

        // Lone requester saturates, then a newcomer forces preemption.
        repeat_cycle(4'b0010, 10);
        repeat_cycle(4'b0011, 4);
        repeat_cycle(4'b0000, 3);

        // Former fixed-priority A/B scenario.
        cycle(4'b0000, 1'b1);
        repeat_cycle(4'b0011, 2);
        repeat_cycle(4'b0010, 4);
        repeat_cycle(4'b0000, 3);

        // Asynchronous reset while requester 3 owns the resource.
        repeat_cycle(4'b1000, 2);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_grant", 32'(grant), 32'd0);
        check("async_valid", 32'(grant_valid), 32'd0);
        check("async_hold", 32'(hold_count), 32'd0);
        cycle(4'b1000, 1'b0);
        check("post_reset_idx", 32'(grant_idx), 32'd3);

        // Random traffic: requests mostly persist, occasionally change or reset.
        r = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
            cycle(r, $urandom_range(0, 99) == 0);
        end
        cycle(4'b0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
